// File: rtl/bcd_7seg_scanner.sv
// Multiplexed 4-digit 7-segment driver. BCD results are captured on the ready pulse,
// applied only at frame boundaries, decoded with leading-zero blanking, and flagged if invalid.
module bcd_7seg_scanner #(
  parameter int CLK_DIV        = 50000,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        err_clr,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] disp_val,
  output logic        err
);

  localparam int             CW      = 21;
  localparam logic [CW-1:0]  LAST    = CW'(CLK_DIV - 1);
  localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   frame_q, frame_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          err_q, err_d;

  logic          tick;
  logic          bad_capture;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_raw;
  logic          d3_z, d2_z, d1_z;

  always_comb begin
    tick     = (count_q == LAST);
    count_d  = tick ? '0 : count_q + CW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = bcd_valid ? bcd_in : shadow_q;

    // A pulse landing on the wrap tick bypasses the shadow so the newest value wins.
    frame_d = frame_q;
    if (tick && idx_q == 2'd3) begin
      frame_d = bcd_valid ? bcd_in : shadow_q;
    end

    bad_capture = (bcd_in[15:12] > 4'd9) || (bcd_in[11:8] > 4'd9) ||
                  (bcd_in[7:4]   > 4'd9) || (bcd_in[3:0]  > 4'd9);
    if (bcd_valid && bad_capture) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_comb begin
    nibble = frame_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'd0:    seg_raw = 7'h3F;
      4'd1:    seg_raw = 7'h06;
      4'd2:    seg_raw = 7'h5B;
      4'd3:    seg_raw = 7'h4F;
      4'd4:    seg_raw = 7'h66;
      4'd5:    seg_raw = 7'h6D;
      4'd6:    seg_raw = 7'h7D;
      4'd7:    seg_raw = 7'h07;
      4'd8:    seg_raw = 7'h7F;
      4'd9:    seg_raw = 7'h6F;
      default: seg_raw = 7'h40;
    endcase

    // Invalid nibbles are non-zero, so they stop blanking like any other digit.
    d3_z  = (frame_q[15:12] == 4'd0);
    d2_z  = (frame_q[11:8]  == 4'd0);
    d1_z  = (frame_q[7:4]   == 4'd0);
    blank = 1'b0;
    if (BLANK_LEADING) begin
      case (idx_q)
        2'd3:    blank = d3_z;
        2'd2:    blank = d3_z && d2_z;
        2'd1:    blank = d3_z && d2_z && d1_z;
        default: blank = 1'b0;
      endcase
    end

    if (blank) begin
      seg_raw = 7'h00;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      frame_q  <= 16'h0000;
      seg_q    <= SEG_OFF;
      an_q     <= 4'b1111;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      err_q    <= err_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign disp_val = frame_q;
  assign err      = err_q;
  assign dp       = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Directed bench for bcd_7seg_scanner: three instances sharing stimulus
// (blanking on, blanking off, and a CLK_DIV=1 active-high variant).
module tb_bcd_7seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        err_clr;

  logic [6:0]  seg1, seg2, seg3;
  logic        dp1, dp2, dp3;
  logic [3:0]  an1, an2, an3;
  logic [15:0] dv1, dv2, dv3;
  logic        err1, err2, err3;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  always #5 clk = ~clk;

  bcd_7seg_scanner #(.CLK_DIV(4), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .err_clr(err_clr),
    .seg(seg1), .dp(dp1), .an(an1), .disp_val(dv1), .err(err1));

  bcd_7seg_scanner #(.CLK_DIV(4), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .err_clr(err_clr),
    .seg(seg2), .dp(dp2), .an(an2), .disp_val(dv2), .err(err2));

  bcd_7seg_scanner #(.CLK_DIV(1), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .err_clr(err_clr),
    .seg(seg3), .dp(dp3), .an(an3), .disp_val(dv3), .err(err3));

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One step = advance to the negedge following the next rising edge.
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  // Walks one full 16-cycle frame, starting with the slot-0 cycle.
  task automatic check_frame(input string name,
                             input logic [6:0] a0, input logic [6:0] a1,
                             input logic [6:0] a2, input logic [6:0] a3,
                             input logic [6:0] b0, input logic [6:0] b1,
                             input logic [6:0] b2, input logic [6:0] b3);
    logic [6:0] ea [4];
    logic [6:0] eb [4];
    logic [3:0] en [4];
    ea = '{a0, a1, a2, a3};
    eb = '{b0, b1, b2, b3};
    en = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("%s_an1_s%0d", name, s), 16'(an1), 16'(en[s]));
        check($sformatf("%s_seg1_s%0d", name, s), 16'(seg1), 16'(ea[s]));
        check($sformatf("%s_an2_s%0d", name, s), 16'(an2), 16'(en[s]));
        check($sformatf("%s_seg2_s%0d", name, s), 16'(seg2), 16'(eb[s]));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bcd_in    = 16'h0000;
    bcd_valid = 1'b0;
    err_clr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an1", 16'(an1), 16'h000F);
    check("rst_seg1", 16'(seg1), 16'h007F);
    check("rst_dp1", 16'(dp1), 16'h0001);
    check("rst_err1", 16'(err1), 16'h0000);
    check("rst_dv1", dv1, 16'h0000);
    check("rst_seg3", 16'(seg3), 16'h0000);
    check("rst_dp3", 16'(dp3), 16'h0000);
    check("rst_an3", 16'(an3), 16'h000F);

    rst_n = 1'b1;
    k = 0;
    #1;
    check("first_cycle_an1", 16'(an1), 16'h000F);

    // First frame after release: units '0', digits 3..1 blank
    check_frame("frame0", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);

    // Capture 0429 during idx=1 (edge 22); held until the wrap at edge 32
    step_to(21);
    bcd_valid = 1'b1;
    bcd_in    = 16'h0429;
    step();
    bcd_valid = 1'b0;
    check("hold_dv1_e22", dv1, 16'h0000);
    check("hold_an1_e22", 16'(an1), 16'h000D);
    check("hold_seg1_e22", 16'(seg1), 16'h007F);
    step_to(31);
    check("hold_dv1_e31", dv1, 16'h0000);
    step_to(32);
    check("wrap_dv1", dv1, 16'h0429);
    check("wrap_dv2", dv2, 16'h0429);
    check("err1_clean", 16'(err1), 16'h0000);
    check_frame("f0429", 7'h10, 7'h24, 7'h19, 7'h7F, 7'h10, 7'h24, 7'h19, 7'h40);

    // CLK_DIV=1 active-high instance: one digit per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      check("d3_dp", 16'(dp3), 16'h0000);
      case (an3)
        4'b1110: check("d3_units", 16'(seg3), 16'h006F);
        4'b1101: check("d3_tens", 16'(seg3), 16'h005B);
        4'b1011: check("d3_hund", 16'(seg3), 16'h0066);
        4'b0111: check("d3_thou", 16'(seg3), 16'h0000);
        default: check("d3_an", 16'(an3), 16'h000E);
      endcase
    end

    // Bypass: pulse exactly on the idx==3 tick (edge 64)
    step_to(63);
    check("pre_bypass_dv1", dv1, 16'h0429);
    bcd_valid = 1'b1;
    bcd_in    = 16'h1234;
    step();
    bcd_valid = 1'b0;
    check("bypass_dv1", dv1, 16'h1234);
    check_frame("f1234", 7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79);

    // Zero value: blanking on vs off
    bcd_valid = 1'b1;
    bcd_in    = 16'h0000;
    step();
    bcd_valid = 1'b0;
    step_to(96);
    check("zero_dv1", dv1, 16'h0000);
    check_frame("f0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);

    // Invalid digit capture sets err the next cycle
    bcd_valid = 1'b1;
    bcd_in    = 16'h00A5;
    step();
    bcd_valid = 1'b0;
    check("inv_err1", 16'(err1), 16'h0001);
    check("inv_err2", 16'(err2), 16'h0001);
    check("inv_dv1_hold", dv1, 16'h0000);
    step_to(128);
    check("inv_dv1", dv1, 16'h00A5);
    check_frame("f00A5", 7'h12, 7'h3F, 7'h7F, 7'h7F, 7'h12, 7'h3F, 7'h40, 7'h40);

    // err_clr alone clears; clear alongside a bad capture loses
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err1", 16'(err1), 16'h0000);
    err_clr   = 1'b1;
    bcd_valid = 1'b1;
    bcd_in    = 16'hF000;
    step();
    err_clr   = 1'b0;
    bcd_valid = 1'b0;
    check("setwins_err1", 16'(err1), 16'h0001);
    step();
    check("sticky_err1", 16'(err1), 16'h0001);
    step_to(160);
    check("fF000_dv1", dv1, 16'hF000);

    // Async reset in the middle of idx=2 (edge 170)
    step_to(170);
    check("mid_an1", 16'(an1), 16'h000B);
    #1 rst_n = 1'b0;
    #1;
    check("async_an1", 16'(an1), 16'h000F);
    check("async_seg1", 16'(seg1), 16'h007F);
    check("async_dv1", dv1, 16'h0000);
    check("async_err1", 16'(err1), 16'h0000);
    check("async_seg3", 16'(seg3), 16'h0000);
    #1 rst_n = 1'b1;
    k = 0;
    #1;
    check("rel_an1", 16'(an1), 16'h000F);
    check_frame("restart", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scanner.md
# bcd_7seg_scanner

Downstream display stage for the 12-bit binary-to-BCD converter. It captures the converter's 16-bit packed BCD result (4 digits) on the converter's one-cycle ready pulse. It time-multiplexes the digits onto a common-segment 4-digit 7-segment display, with leading-zero blanking and invalid-digit flagging. The captured value is applied at a frame boundary only, so a displayed number never tears mid-scan.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; legal range 1..2^20.
- BLANK_LEADING, 1: 1 blanks leading zero digits 3..1; 0 shows all digits.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are active-low (0 lights a segment); 0 means active-high.

- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- bcd_in  in  16  packed BCD from the converter: [15:12] thousands … [3:0] units
- bcd_valid  in  1  one-cycle pulse; bcd_in is valid in this cycle (driven by converter rdy)
- err_clr  in  1  synchronous clear of err
- seg  out  7  segment drive {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW
- dp  out  1  decimal point; always off (1 if SEG_ACTIVE_LOW, else 0)
- an  out  4  digit enables, one-hot active-low; an[i] selects digit i (an[0] = units)
- disp_val  out  16  BCD value currently being scanned (frame register)
- err  out  1  sticky flag: a captured nibble was > 9

## Operation
- Shadow register: on any edge with bcd_valid=1, shadow <= bcd_in. Back-to-back pulses: the last one wins.
- Prescaler: the counter runs 0..CLK_DIV-1 and wraps. tick=1 in the cycle where count==CLK_DIV-1. CLK_DIV=1 gives tick=1 every cycle.
- Digit index: 2-bit idx advances on tick, sequence 0→1→2→3→0.
- Frame update: on a tick with idx==3 (wrap to 0), frame <= shadow.
  - If bcd_valid is also 1 in that cycle, frame <= bcd_in (bypass), so the newest value always wins.
- disp_val = frame.
- Decode of the frame nibble selected by idx, shown as active-high patterns (inverted when SEG_ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble 10..15 shows '-' = 40.
- Leading-zero blanking (BLANK_LEADING=1):
  - digit 3 is blank if d3==0;
  - digit 2 is blank if d3==0 and d2==0;
  - digit 1 is blank if d3, d2 and d1 are all 0;
  - digit 0 is never blank.
  - A blank slot still drives its an bit low, but all segments are off.
  - A non-zero invalid nibble (>9) counts as non-zero for blanking.
- err: set on any edge where a capture (bcd_valid=1) has any nibble > 9. Cleared by err_clr=1 only when no such capture happens in the same cycle; a set in the same cycle wins.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - count=0, idx=0, shadow=0, frame=0;
  - an=4'b1111, seg=all off, dp=off, err=0, disp_val=0.
- Outputs: seg and an are registered. They reflect the idx/frame state of the previous cycle, i.e. one cycle of latency after an idx change. an is never all-ones except during reset and the first cycle after reset release.
- First cycle after rst_n rises:
  - outputs are still at reset values;
  - the second cycle drives an=1110 and units '0'.
- Each digit slot lasts exactly CLK_DIV cycles; the frame period is 4*CLK_DIV cycles.
- Capture-to-display latency: at most 4*CLK_DIV+1 cycles from bcd_valid to the new value appearing on seg, and at least 1 cycle (bypass case).
- A capture at any time other than the wrap tick does not change frame or seg until the next wrap.
- Reset asserted mid-frame aborts the scan immediately. The next frame starts at idx 0 with value 0.

## Test plan
- Reset / first frame:
  - Setup: CLK_DIV=4, rst_n low then released, no capture.
  - Required: an follows 1110,1101,1011,0111, each 4 cycles, first change 1 cycle after release.
  - Required: units shows 0x40 (the '0' pattern 3F inverted); digits 3..1 are all-off (7F).
- Capture and frame-boundary application:
  - Stimulus: bcd_valid pulse with bcd_in=16'h0429 at idx=1.
  - Required: display is unchanged until the wrap; the next frame shows units '9', tens '2', hundreds '4', thousands blank; disp_val=0429.
- Bypass at wrap:
  - Stimulus: pulse bcd_in=16'h1234 exactly on the idx==3 tick.
  - Required: disp_val=1234 on the next cycle; all four digits are lit.
- Blanking off / zero value:
  - Setup: BLANK_LEADING=0, capture 16'h0000.
  - Required: all four slots show '0' (active-low 40).
- Invalid digits and err:
  - Stimulus: capture 16'h00A5.
  - Required: err=1 the next cycle; tens shows '-' (active-low 3F); hundreds and thousands are blank.
  - Stimulus: err_clr pulse. Required: err=0.
  - Stimulus: err_clr together with a capture of 16'hF000. Required: err stays 1.
- Async reset mid-scan:
  - Stimulus: rst_n low for 2 ns in the middle of idx=2.
  - Required: an=1111 and seg all off immediately, without waiting for a clock edge; after release the scan restarts at idx 0 showing '0'.
